// File: rtl/demux1x4_buf.sv
// 1-to-4 demultiplexer with a two-entry FIFO per output channel.
// Each channel also keeps an 8-bit count of the bytes its consumer has taken.
module demux1x4_buf #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [DATA_W-1:0] out_c,
   output logic [DATA_W-1:0] out_d,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [31:0]       xfer_cnt
);

   localparam int unsigned NCH   = 4;
   localparam int unsigned CNT_W = 8;

   if (DEPTH != 2) begin : g_depth_check
      $error("demux1x4_buf supports DEPTH=2 only");
   end

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fill_t;

   fill_t             state_q [NCH];
   fill_t             state_d [NCH];
   logic [DATA_W-1:0] head_q  [NCH];
   logic [DATA_W-1:0] head_d  [NCH];
   logic [DATA_W-1:0] tail_q  [NCH];
   logic [DATA_W-1:0] tail_d  [NCH];
   logic [CNT_W-1:0]  cnt_q   [NCH];
   logic [CNT_W-1:0]  cnt_d   [NCH];
   logic [NCH-1:0]    push;
   logic [NCH-1:0]    pop;

   // A full channel never accepts, even if it is being drained this cycle.
   always_comb begin
      in_ready = !rst && (state_q[in_sel] != FULL);
   end

   always_comb begin
      push = '0;
      pop  = '0;
      for (int k = 0; k < NCH; k++) begin
         push[k] = in_valid && in_ready && (in_sel == 2'(k));
         pop[k]  = out_ready[k] && (state_q[k] != EMPTY);
      end
   end

   // Per-channel next-state: head holds the oldest byte, tail the second one.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      for (int k = 0; k < NCH; k++) begin
         case ({push[k], pop[k]})
            2'b10: begin
               if (state_q[k] == EMPTY) begin
                  head_d[k]  = in_data;
                  state_d[k] = ONE;
               end else begin
                  tail_d[k]  = in_data;
                  state_d[k] = FULL;
               end
            end
            2'b01: begin
               head_d[k]  = tail_q[k];
               tail_d[k]  = '0;
               state_d[k] = (state_q[k] == FULL) ? ONE : EMPTY;
               cnt_d[k]   = cnt_q[k] + CNT_W'(1);
            end
            2'b11: begin
               // Only reachable in ONE: the new byte replaces the departing head.
               head_d[k] = in_data;
               cnt_d[k]  = cnt_q[k] + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            state_q[k] <= EMPTY;
            head_q[k]  <= '0;
            tail_q[k]  <= '0;
            cnt_q[k]   <= '0;
         end
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      out_valid = '0;
      for (int k = 0; k < NCH; k++) begin
         out_valid[k] = (state_q[k] != EMPTY);
      end
   end

   assign out_a    = head_q[0];
   assign out_b    = head_q[1];
   assign out_c    = head_q[2];
   assign out_d    = head_q[3];
   assign xfer_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_demux1x4_buf.sv
// Bench for demux1x4_buf: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux1x4_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = '0;
   logic [1:0]  in_sel = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  out_a, out_b, out_c, out_d;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = '0;
   logic [31:0] xfer_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mq [4][$];
   logic [7:0] mcnt [4];

   demux1x4_buf #(.DATA_W(8), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
      .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
      .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_head(input int k);
      return (mq[k].size() > 0) ? mq[k][0] : 8'h00;
   endfunction

   // Reference model: one byte queue and one wrapping count per channel.
   always @(posedge clk) begin
      if (!rst) begin
         logic       do_push;
         logic [1:0] s;
         logic [7:0] d;
         s = in_sel;
         d = in_data;
         do_push = in_valid && (mq[s].size() < 2);
         for (int k = 0; k < 4; k++) begin
            if (out_ready[k] && mq[k].size() > 0) begin
               void'(mq[k].pop_front());
               mcnt[k] = mcnt[k] + 8'd1;
            end
         end
         if (do_push) mq[s].push_back(d);
      end
   end

   always @(posedge rst) begin
      for (int k = 0; k < 4; k++) begin
         mq[k].delete();
         mcnt[k] = 8'h00;
      end
   end

   // Per-cycle comparison against the model, mid-way through the low phase.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         logic [3:0] ev;
         for (int k = 0; k < 4; k++) ev[k] = (mq[k].size() > 0);
         check("model out_valid", 32'(out_valid), 32'(ev));
         check("model out_a", 32'(out_a), 32'(m_head(0)));
         check("model out_b", 32'(out_b), 32'(m_head(1)));
         check("model out_c", 32'(out_c), 32'(m_head(2)));
         check("model out_d", 32'(out_d), 32'(m_head(3)));
         check("model xfer_cnt", xfer_cnt, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
         check("model in_ready", 32'(in_ready), 32'(mq[in_sel].size() < 2));
      end
   end

   task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 4'b0000;
   endtask

   // Reset pulse strictly between two rising edges; outputs must clear at once.
   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      in_sel    = 2'd1;
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst outs", {out_a, out_b, out_c, out_d}, 32'h0);
      check("rst xfer_cnt", xfer_cnt, 32'h0);
      check("rst in_ready", 32'(in_ready), 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) mcnt[k] = 8'h00;
      #3;
      check("init out_valid", 32'(out_valid), 32'h0);
      check("init xfer_cnt", xfer_cnt, 32'h0);
      check("init in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      #3 rst = 1'b0;

      // Single byte to channel c, visible the cycle after acceptance.
      cyc(1'b1, 2'd2, 8'h5A, 4'b0000);
      @(negedge clk);
      check("c out_valid", 32'(out_valid), 32'h4);
      check("c out_c", 32'(out_c), 32'h5A);
      check("c others", {out_a, out_b, out_d}, 32'h0);
      check("c xfer", xfer_cnt, 32'h0);

      // Fill channel a, third push refused, then drain.
      do_reset();
      cyc(1'b1, 2'd0, 8'h11, 4'b0000);
      cyc(1'b1, 2'd0, 8'h22, 4'b0000);
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h33;
      #1 check("a full in_ready", 32'(in_ready), 32'h0);
      cyc(1'b1, 2'd0, 8'h33, 4'b0000);
      @(negedge clk);
      check("a full head", 32'(out_a), 32'h11);
      check("a full valid", 32'(out_valid), 32'h1);
      cyc(1'b0, 2'd0, 8'h00, 4'b0001);
      @(negedge clk);
      check("a pop1 head", 32'(out_a), 32'h22);
      cyc(1'b0, 2'd0, 8'h00, 4'b0001);
      @(negedge clk);
      check("a empty valid", 32'(out_valid), 32'h0);
      check("a empty head", 32'(out_a), 32'h0);
      check("a xfer", 32'(xfer_cnt[7:0]), 32'h2);

      // Push and pop together on a channel holding one byte.
      do_reset();
      cyc(1'b1, 2'd1, 8'h01, 4'b0000);
      @(negedge clk);
      check("b one head", 32'(out_b), 32'h01);
      cyc(1'b1, 2'd1, 8'h02, 4'b0010);
      @(negedge clk);
      check("b swap valid", 32'(out_valid), 32'h2);
      check("b swap head", 32'(out_b), 32'h02);
      check("b swap xfer", 32'(xfer_cnt[15:8]), 32'h1);

      // Full channel d: a same-cycle pop does not open it for a push.
      do_reset();
      cyc(1'b1, 2'd3, 8'hAA, 4'b0000);
      cyc(1'b1, 2'd3, 8'hBB, 4'b0000);
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hCC; out_ready = 4'b1000;
      #1 check("d full in_ready", 32'(in_ready), 32'h0);
      cyc(1'b1, 2'd3, 8'hCC, 4'b1000);
      @(negedge clk);
      check("d one head", 32'(out_d), 32'hBB);
      check("d one valid", 32'(out_valid), 32'h8);
      check("d xfer", 32'(xfer_cnt[31:24]), 32'h1);
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hDD;
      #1 check("d reopen in_ready", 32'(in_ready), 32'h1);
      cyc(1'b1, 2'd3, 8'hDD, 4'b0000);
      cyc(1'b0, 2'd0, 8'h00, 4'b1000);
      @(negedge clk);
      check("d second byte", 32'(out_d), 32'hDD);

      // All four channels popped in one cycle.
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1'b1, 2'(k), 8'(8'h10 * (k + 1)), 4'b0000);
      @(negedge clk);
      check("all one valid", 32'(out_valid), 32'hF);
      check("all one heads", {out_d, out_c, out_b, out_a}, 32'h40302010);
      cyc(1'b0, 2'd0, 8'h00, 4'b1111);
      @(negedge clk);
      check("all pop valid", 32'(out_valid), 32'h0);
      check("all pop xfer", xfer_cnt, 32'h01010101);

      // Count wrap on channel a: 256 pops.
      do_reset();
      for (int i = 0; i < 255; i++) cyc(1'b1, 2'd0, 8'(i), 4'b0001);
      cyc(1'b1, 2'd0, 8'hEE, 4'b0001);
      @(negedge clk);
      check("wrap 255", 32'(xfer_cnt[7:0]), 32'hFF);
      cyc(1'b0, 2'd0, 8'h00, 4'b0001);
      @(negedge clk);
      check("wrap 0", 32'(xfer_cnt[7:0]), 32'h0);
      check("wrap empty", 32'(out_valid), 32'h0);

      // Mid-operation reset with data in a and c.
      do_reset();
      cyc(1'b1, 2'd0, 8'h71, 4'b0000);
      cyc(1'b1, 2'd2, 8'h72, 4'b0000);
      cyc(1'b0, 2'd0, 8'h00, 4'b0100);
      do_reset();
      @(negedge clk);
      check("post rst valid", 32'(out_valid), 32'h0);
      check("post rst xfer", xfer_cnt, 32'h0);

      // Randomized traffic with occasional asynchronous reset pulses.
      @(posedge clk);
      #1;
      for (int i = 0; i < 4000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = 8'($urandom);
         out_ready = 4'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            @(negedge clk);
            #3 rst = 1'b1;
            #1 rst = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      @(negedge clk);
      #4;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/demux1x4_buf.md
DEMUX1X4_BUF -- requirements
Module: demux1x4_buf

Interface
REQ-001: Parameter DATA_W, default 8, width of every data path.
REQ-002: Parameter DEPTH, fixed at 2, entries per output channel buffer; other values SHALL NOT be supported.
REQ-003: clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004: rst  in  1  asynchronous, active-high reset.
REQ-005: in_data  in  DATA_W  byte to route.
REQ-006: in_sel  in  2  destination channel: 00=a, 01=b, 10=c, 11=d.
REQ-007: in_valid  in  1  in_data/in_sel valid this cycle.
REQ-008: in_ready  out  1  destination channel can accept this cycle.
REQ-009: out_a, out_b, out_c, out_d  out  DATA_W each  head entry of each channel buffer.
REQ-010: out_valid  out  4  bit k set = channel k head valid (bit0=a ... bit3=d).
REQ-011: out_ready  in  4  bit k set = channel k consumer takes head this cycle.
REQ-012: xfer_cnt  out  32  per-channel delivered-byte count, channel k in bits [8k+7:8k].

Function
REQ-013: in_ready SHALL be combinational: 1 iff rst low and the channel selected by in_sel holds fewer than 2 entries.
REQ-014: A push SHALL occur on a clock edge where in_valid and in_ready are both 1; in_data SHALL be written to channel in_sel only.
REQ-015: in_sel and in_data SHALL be ignored when in_valid is 0; at most one channel SHALL receive a push per cycle.
REQ-016: A pop on channel k SHALL occur on a clock edge where out_valid[k] and out_ready[k] are both 1; pops on different channels SHALL be independent and may all occur in one cycle.
REQ-017: Each channel SHALL be a FIFO with states EMPTY (0 entries), ONE (1), FULL (2); push-only: EMPTY->ONE, ONE->FULL; pop-only: FULL->ONE, ONE->EMPTY; push and pop together in ONE: stay ONE, head replaced by the pushed byte; no event: hold.
REQ-018: A push to a FULL channel SHALL be impossible because in_ready is 0; a same-cycle pop SHALL NOT enable it (no pass-through).
REQ-019: out_valid[k] SHALL be 1 iff channel k is not EMPTY, driven from registers.
REQ-020: out_x SHALL present the oldest entry of its channel; it SHALL be 0 when the channel is EMPTY.
REQ-021: Latency: a byte pushed at edge N SHALL appear on its output, with out_valid set, after edge N; no combinational path from in_* to out_*.
REQ-022: Per-channel order SHALL be preserved; no byte SHALL be dropped, duplicated or routed to a channel other than in_sel at acceptance.
REQ-023: xfer_cnt channel k SHALL increment by 1 on every pop of channel k, wrapping 255->0.
REQ-024: out_ready[k] asserted while out_valid[k] is 0 SHALL have no effect.

Reset
REQ-025: While rst is 1, all channels SHALL be EMPTY, out_valid=0000, out_a..out_d=0, xfer_cnt=0, in_ready=0, independent of clk.
REQ-026: Asserting rst mid-operation SHALL discard all buffered bytes immediately; no pop or count SHALL be credited for them.
REQ-027: After rst deasserts, the first push SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-028: Reset, then in_valid=1, in_sel=10, in_data=0x5A for one cycle -> next cycle out_valid=0100, out_c=0x5A, other outputs 0.
REQ-029: out_ready=0000; push 0x11, 0x22, 0x33 to channel a on consecutive cycles -> in_ready=0 on third cycle, channel a FULL, out_a=0x11; then out_ready[0]=1 two cycles -> out_a 0x22 then EMPTY, xfer_cnt[7:0]=2.
REQ-030: Channel b in ONE holding 0x01; same cycle push 0x02 to b and out_ready[1]=1 -> b stays ONE, out_b=0x02, xfer_cnt[15:8] +1.
REQ-031: Channel d FULL, out_ready[3]=1, in_sel=11, in_valid=1 -> in_ready=0, no push, d becomes ONE; next cycle push accepted.
REQ-032: All four channels ONE, out_ready=1111 one cycle -> out_valid=0000, each xfer_cnt field +1; channel count 255 plus one pop -> field 0.
REQ-033: Channels a and c holding data, rst pulsed high for a partial cycle between edges -> out_valid=0000, outputs 0, xfer_cnt=0 immediately, in_ready=0 during pulse.
